// File: rtl/pio_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_ram_pkg
//  Description : Shared constants and types for the PIO RAM TX command path.
//                Holds the command header nibbles, the idle nibble, the nibble
//                width and the transaction-kind enum used for read/write
//                fairness tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_ram_pkg;

    localparam int         NIBBLE_W    = 4;
    localparam logic [3:0] CMD_READ    = 4'h1;
    localparam logic [3:0] CMD_WRITE   = 4'h2;
    localparam logic [3:0] IDLE_NIBBLE = 4'h0;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_kind_t;

    // Nibbles on the wire for a transaction carrying 'bits' payload bits:
    // one header nibble plus the payload split into whole nibbles.
    function automatic int nibble_count(input int bits);
        return 1 + bits / NIBBLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_ram_tx_nibble_shift_out.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_shift_out
//  Description : Load/stall-controlled nibble serializer. A load places the
//                lowest nibble of load_data_i on nibble_o the following cycle
//                and queues the rest; each non-stalled cycle advances by one
//                nibble, LSB first, until load_count_i nibbles have been shown.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                load_i          - start a new word (overrides advance)
//                load_data_i     - word to serialize
//                load_count_i    - number of nibbles to present
//                stall_i         - hold the current nibble and counter
//                nibble_o        - registered nibble output (IDLE when empty)
//                valid_o         - registered, high while a nibble is shown
//                last_o          - the nibble on nibble_o is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_shift_out
    import pio_ram_pkg::*;
#(
    parameter int         WIDTH       = 36,
    parameter int         CNT_W       = 4,
    parameter logic [3:0] IDLE_NIBBLE = pio_ram_pkg::IDLE_NIBBLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [CNT_W-1:0] load_count_i,
    input  logic             stall_i,
    output logic [3:0]       nibble_o,
    output logic             valid_o,
    output logic             last_o
);

    // shift_q holds the nibbles not yet shown; count_q counts the nibble on
    // nibble_o plus everything still waiting in shift_q.
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NIBBLE_W-1:0] nibble_q, nibble_d;
    logic                valid_q, valid_d;

    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        nibble_d = nibble_q;
        if (load_i) begin
            nibble_d = load_data_i[NIBBLE_W-1:0];
            shift_d  = {{NIBBLE_W{1'b0}}, load_data_i[WIDTH-1:NIBBLE_W]};
            count_d  = load_count_i;
        end else if (!stall_i && count_q != '0) begin
            count_d  = count_q - CNT_W'(1);
            shift_d  = {{NIBBLE_W{1'b0}}, shift_q[WIDTH-1:NIBBLE_W]};
            nibble_d = (count_d != '0) ? shift_q[NIBBLE_W-1:0] : IDLE_NIBBLE;
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            count_q  <= '0;
            nibble_q <= IDLE_NIBBLE;
            valid_q  <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            count_q  <= count_d;
            nibble_q <= nibble_d;
            valid_q  <= valid_d;
        end
    end

    assign nibble_o = nibble_q;
    assign valid_o  = valid_q;
    assign last_o   = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pio_ram_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pio_ram_tx
//  Description : Command serializer from the RAM clients (pixel writer and
//                scanout reader) to the 4-bit TX bus of the PIO RAM emulator.
//                Captures write address/data pairs and read requests, then
//                sends each transaction as header + address (+ data) nibbles,
//                LSB first, honouring tx_stall back-pressure.
//  Ports       : clk, reset                - clock, sync active-high reset
//                write_en, write_mode_data - writer offers addr (0) / data (1)
//                w_addr, w_data            - offered write address / data
//                write_accepted            - offered word taken this cycle
//                read_req, read_addr       - read request and its address
//                read_accepted             - read request taken this cycle
//                tx_stall                  - PIO cannot take a nibble
//                tx_data, tx_valid         - registered nibble bus to the PIO
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_ram_tx
    import pio_ram_pkg::*;
#(
    parameter int         ADDR_BITS   = 16,
    parameter int         DATA_BITS   = 16,
    parameter logic [3:0] CMD_READ    = pio_ram_pkg::CMD_READ,
    parameter logic [3:0] CMD_WRITE   = pio_ram_pkg::CMD_WRITE,
    parameter logic [3:0] IDLE_NIBBLE = pio_ram_pkg::IDLE_NIBBLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic                 write_mode_data,
    input  logic [ADDR_BITS-1:0] w_addr,
    input  logic [DATA_BITS-1:0] w_data,
    output logic                 write_accepted,
    input  logic                 read_req,
    input  logic [ADDR_BITS-1:0] read_addr,
    output logic                 read_accepted,
    input  logic                 tx_stall,
    output logic [3:0]           tx_data,
    output logic                 tx_valid
);

    localparam int SHIFT_W       = NIBBLE_W + ADDR_BITS + DATA_BITS;
    localparam int READ_NIBBLES  = nibble_count(ADDR_BITS);
    localparam int WRITE_NIBBLES = nibble_count(ADDR_BITS + DATA_BITS);
    localparam int CNT_W         = $clog2(WRITE_NIBBLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               state_q;
    logic                 waddr_valid_q;
    logic                 wdata_valid_q;
    logic [ADDR_BITS-1:0] waddr_q;
    logic [DATA_BITS-1:0] wdata_q;
    txn_kind_t            last_kind_q;

    logic                 tx_last;
    logic                 start_slot;
    logic                 write_ready;
    logic                 start_read;
    logic                 start_write;
    logic                 addr_accept;
    logic                 data_accept;
    logic [SHIFT_W-1:0]   load_data;
    logic [CNT_W-1:0]     load_count;

    // A new transaction may start when the line is idle, or on the cycle the
    // final nibble is leaving so the next header follows with no gap.
    assign start_slot  = !tx_stall &&
                         ((state_q == ST_IDLE) || (state_q == ST_SEND && tx_last));
    assign write_ready = waddr_valid_q && wdata_valid_q;

    // Read wins if no write is ready, or if the last transaction was a write;
    // with both pending they alternate.
    assign start_read  = start_slot && read_req &&
                         (!write_ready || (last_kind_q == TXN_WRITE));
    assign start_write = start_slot && write_ready && !start_read;

    // A starting write frees the address slot in the same cycle, so a fresh
    // address can be captured right away.
    assign addr_accept = write_en && !write_mode_data && (!waddr_valid_q || start_write);
    assign data_accept = write_en && write_mode_data && waddr_valid_q && !wdata_valid_q;

    assign write_accepted = addr_accept || data_accept;
    assign read_accepted  = start_read;

    always_comb begin
        load_data  = {wdata_q, waddr_q, CMD_WRITE};
        load_count = CNT_W'(WRITE_NIBBLES);
        if (start_read) begin
            load_data  = {{DATA_BITS{1'b0}}, read_addr, CMD_READ};
            load_count = CNT_W'(READ_NIBBLES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            waddr_valid_q <= 1'b0;
            wdata_valid_q <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            last_kind_q   <= TXN_READ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_read || start_write) begin
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_last && !tx_stall && !start_read && !start_write) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (start_read) begin
                last_kind_q <= TXN_READ;
            end else if (start_write) begin
                last_kind_q <= TXN_WRITE;
            end

            // Clear on start first, then a same-cycle accept re-sets the flag.
            if (addr_accept) begin
                waddr_valid_q <= 1'b1;
                waddr_q       <= w_addr;
            end else if (start_write) begin
                waddr_valid_q <= 1'b0;
            end

            if (data_accept) begin
                wdata_valid_q <= 1'b1;
                wdata_q       <= w_data;
            end else if (start_write) begin
                wdata_valid_q <= 1'b0;
            end
        end
    end

    nibble_shift_out #(
        .WIDTH       (SHIFT_W),
        .CNT_W       (CNT_W),
        .IDLE_NIBBLE (IDLE_NIBBLE)
    ) u_shift (
        .clk          (clk),
        .reset        (reset),
        .load_i       (start_read || start_write),
        .load_data_i  (load_data),
        .load_count_i (load_count),
        .stall_i      (tx_stall),
        .nibble_o     (tx_data),
        .valid_o      (tx_valid),
        .last_o       (tx_last)
    );

endmodule
`default_nettype wire

// File: doc/pio_ram_tx.md
Name: pio_ram_tx

Overview:
- Command serializer between the RAM-client blocks (julia pixel writer, scanout reader) and the 4-bit TX pin bus to the RP2040 PIO RAM emulator.
- Captures write address/data pairs via the julia write handshake and read requests via a simple req/accept handshake.
- Serializes each transaction as nibbles on tx_data, honouring PIO back-pressure (tx_stall).

Parameters:
- ADDR_BITS, 16, address width (whole nibbles).
- DATA_BITS, 16, write data width (whole nibbles).
- CMD_READ, 4'h1, header nibble for a read transaction.
- CMD_WRITE, 4'h2, header nibble for a write transaction.
- IDLE_NIBBLE, 4'h0, value driven on tx_data when no transaction is in flight.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- write_en  in  1  writer has an address (write_mode_data=0) or data word (=1) available.
- write_mode_data  in  1  0 = offering address, 1 = offering data.
- w_addr  in  ADDR_BITS  write address.
- w_data  in  DATA_BITS  write data.
- write_accepted  out  1  one-cycle pulse: offered address/data word taken this cycle.
- read_req  in  1  reader requests a read.
- read_addr  in  ADDR_BITS  read address, valid while read_req.
- read_accepted  out  1  one-cycle pulse: read request taken this cycle.
- tx_stall  in  1  PIO side cannot take a nibble; hold current output. Already synchronous to clk.
- tx_data  out  4  nibble bus to the PIO.
- tx_valid  out  1  high while tx_data carries a transaction nibble.

Behaviour:
- Reset state: tx_data=IDLE_NIBBLE, tx_valid=0, write_accepted=0, read_accepted=0, both capture-valid flags clear, FSM IDLE, nibble counter 0, fairness flag clear.
- Write capture runs independently of TX:
  - Address is accepted when write_en && !write_mode_data && !waddr_valid. Latch w_addr, set waddr_valid.
  - Data is accepted when write_en && write_mode_data && waddr_valid && !wdata_valid. Latch w_data, set wdata_valid.
  - write_accepted is combinational from these terms and registered state.
  - Address and data are never both accepted in one cycle.
- FSM states: IDLE, SEND.
  - A start slot exists in IDLE, or in SEND when the final nibble is on tx_data and tx_stall=0. This gives gapless back-to-back transactions.
- Arbitration at a start slot:
  - If read_req and (!write_ready or last_was_write): start a read, pulse read_accepted.
  - Else if write_ready (waddr_valid && wdata_valid): start a write, clear both valid flags in the same cycle.
  - last_was_write records the type of the last started transaction. Reads and writes alternate when both are pending, so neither starves.
  - A read takes priority when no write is ready.
  - If the capture logic would accept a new address in the same cycle a write starts, the accept is allowed (flags clear first, then set).
- Shift register: 4+ADDR_BITS+DATA_BITS bits, loaded on start.
  - Read = {read_addr, CMD_READ}.
  - Write = {w_data_reg, w_addr_reg, CMD_WRITE}.
  - Nibbles go out LSB first: header, then address low to high, then data low to high.
  - tx_data/tx_valid are registered. The header appears the cycle after the accept/start.
  - Nibble count: read = 1+ADDR_BITS/4 (5); write = 1+(ADDR_BITS+DATA_BITS)/4 (9).
- tx_stall=1: shift register, counter and tx_data/tx_valid hold. No start slot opens. Accepts into the write capture registers continue.
- After the last nibble with no new start: tx_data=IDLE_NIBBLE, tx_valid=0 next cycle.
- reset mid-transaction: the transaction is abandoned and all state returns to reset values next cycle. No partial resume.

Decomposition:
- Package pio_ram_pkg holds CMD_READ, CMD_WRITE, IDLE_NIBBLE, the nibble width (4), and a txn_kind enum (TXN_READ, TXN_WRITE).
- One sub-module, nibble_shift_out: load/stall-controlled shift register plus remaining-nibble counter. It provides the last-nibble flag.
- Arbitration and write capture live in the top.

Test Plan:
- Read 0x1234, no stall: read_accepted pulse at T. tx_data = 1,4,3,2,1 at T+1..T+5 with tx_valid=1, then 0/tx_valid=0.
- Write addr 0x00A5, data 0xBEEF: two write_accepted pulses (address, then data). Then tx_data = 2,5,A,0,0,F,E,E,B, 9 valid cycles.
- Read and write both pending at the same start slot, last_was_write=0: write goes first. Next slot serves the read, with no idle nibble between them.
- tx_stall high for 3 cycles at nibble 3 of a write: tx_data holds for 3 extra cycles. The sequence is otherwise unchanged; total 12 valid cycles.
- Second write pair offered during a transmit: address and data accepted while SEND. The next write starts exactly at the last nibble with no gap.
- reset asserted at nibble 4 of a write: next cycle tx_valid=0, tx_data=0, valid flags clear. A following read 0xFFFF gives 1,F,F,F,F.
